han_carl_sub_pipe: RTL

Pipelined 2-stage unsigned/two's-complement subtractor, d = a - b, built on a Han-Carlson parallel-prefix borrow tree. It is the inverse-direction companion to the team's combinational Han-Carlson adder and the subtract path for ALU/compare datapaths.
It sits between a valid/ready producer and a valid/ready consumer. It sustains one operation per cycle and holds results under backpressure.

---
 rtl/han_carl_sub_pipe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/han_carl_sub_pipe.sv
// -----------------------------------------------------------------------------
// han_carl_sub_pipe
//   Two-stage pipelined subtractor d = a - b (modulo 2^WIDTH) built on a
//   Han-Carlson parallel-prefix borrow tree. It sits between a valid/ready
//   producer and a valid/ready consumer. It sustains one operation per cycle
//   and holds its result under backpressure.
//
// Ports
//   clk        : clock, all state on the rising edge
//   reset      : asynchronous assert, active-low reset
//   in_valid   : operand pair a/b is valid
//   in_ready   : block accepts a/b this cycle (combinational from out_ready)
//   a, b       : minuend / subtrahend, WIDTH bits
//   out_valid  : result valid
//   out_ready  : consumer accepts the result this cycle
//   d          : a - b modulo 2^WIDTH (registered)
//   borrow     : 1 iff unsigned a < b (registered)
//   zero       : 1 iff d == 0 (registered)
//   ovf        : signed overflow of the subtraction (registered)
// -----------------------------------------------------------------------------
module han_carl_sub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  // Remaining Han-Carlson levels after the span-1 level. Odd bits merge at
  // spans 2, 4, ... WIDTH/2 and end up holding the full group generate
  // [i:0]. Each even bit then takes one fix-up merge with its odd neighbour
  // below. The carry-in of 1 is already folded into g1[0], so the returned
  // vector is the carry out of every bit position.
  function automatic logic [WIDTH-1:0] hc_carries(input logic [WIDTH-1:0] g1,
                                                  input logic [WIDTH-1:0] p1);
    logic [WIDTH-1:0] g_cur;
    logic [WIDTH-1:0] p_cur;
    logic [WIDTH-1:0] g_nxt;
    logic [WIDTH-1:0] p_nxt;
    g_cur = g1;
    p_cur = p1;
    for (int s = 2; s < WIDTH; s = s * 2) begin
      g_nxt = g_cur;
      p_nxt = p_cur;
      // Odd bits below s+1 already cover [i:0] and pass straight through.
      for (int i = s + 1; i < WIDTH; i = i + 2) begin
        g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i-s]);
        p_nxt[i] = p_cur[i] & p_cur[i-s];
      end
      g_cur = g_nxt;
      p_cur = p_nxt;
    end
    // Even bits still hold only their own bit. Merge each with the completed odd bit below.
    for (int i = 2; i < WIDTH; i = i + 2) begin
      g_cur[i] = g_cur[i] | (p_cur[i] & g_cur[i-1]);
    end
    return g_cur;
  endfunction

  // Stage 1 state
  logic             v1_q,    v1_d;
  logic [WIDTH-1:0] h_q,     h_d;
  logic [WIDTH-1:0] g1_q,    g1_d;
  logic [WIDTH-1:0] p1_q,    p1_d;
  logic             a_msb_q;
  logic             b_msb_q;

  // Stage 2 (output) state
  logic             v2_q,    v2_d;
  logic [WIDTH-1:0] d_q,     d_d;
  logic             borrow_q, borrow_d;
  logic             zero_q,   zero_d;
  logic             ovf_q,    ovf_d;

  // Handshake and combinational datapath signals
  logic             s1_load_s;
  logic             s2_load_s;
  logic [WIDTH-1:0] nb_s;
  logic [WIDTH-1:0] g0_s;
  logic [WIDTH-1:0] carry_s;

  // Pipeline advance and valid next-state
  always_comb begin
    s2_load_s = v1_q && (!v2_q || out_ready);
    in_ready  = !v1_q || !v2_q || out_ready;
    s1_load_s = in_valid && in_ready;
    if (s1_load_s) begin
      v1_d = 1'b1;
    end else if (s2_load_s) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
    if (s2_load_s) begin
      v2_d = 1'b1;
    end else if (out_ready) begin
      v2_d = 1'b0;
    end else begin
      v2_d = v2_q;
    end
  end

  // Bitwise gen/prop/half-sum on a and ~b, then the span-1 prefix level
  always_comb begin
    nb_s  = ~b;
    h_d   = a ^ nb_s;
    g0_s  = a & nb_s;
    // The carry-in of 1 makes bit 0 generate whenever it would propagate.
    g0_s[0] = a[0] | nb_s[0];
    g1_d  = g0_s;
    p1_d  = h_d;
    for (int i = 1; i < WIDTH; i = i + 2) begin
      g1_d[i] = g0_s[i] | (h_d[i] & g0_s[i-1]);
      p1_d[i] = h_d[i] & h_d[i-1];
    end
  end

  // Remaining prefix levels, sum XOR and flags from the stage-1 register
  always_comb begin
    carry_s  = hc_carries(g1_q, p1_q);
    d_d      = h_q ^ {carry_s[WIDTH-2:0], 1'b1};
    borrow_d = ~carry_s[WIDTH-1];
    zero_d   = (d_d == {WIDTH{1'b0}});
    ovf_d    = (a_msb_q ^ b_msb_q) & (d_d[WIDTH-1] ^ a_msb_q);
  end

  // Pipeline registers. Data only moves on a stage load, so results hold under stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q     <= 1'b0;
      h_q      <= {WIDTH{1'b0}};
      g1_q     <= {WIDTH{1'b0}};
      p1_q     <= {WIDTH{1'b0}};
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      v2_q     <= 1'b0;
      d_q      <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (s1_load_s) begin
        h_q     <= h_d;
        g1_q    <= g1_d;
        p1_q    <= p1_d;
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= b[WIDTH-1];
      end
      if (s2_load_s) begin
        d_q      <= d_d;
        borrow_q <= borrow_d;
        zero_q   <= zero_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign out_valid = v2_q;
  assign d         = d_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule
